// File: rtl/alu_dec_md_pkg.sv
// alu_dec_md_pkg
//   Shared decode constants for the D->E ALU-op decoder: MIPS opcode,
//   funct and rs field values, ALU opcode encodings, the instruction
//   decode table, and helpers that classify HI/LO multiply/divide ops.
//   ALU opcodes are 8 bits here. Instantiating modules resize them to
//   their ALUOP_W parameter.
//   Every table entry decodes to a non-zero ALU opcode, and that
//   includes SLL/NOP. As a result, a decode miss is exactly
//   "decoded opcode == ALUOP_NONE".
package alu_dec_md_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FUN_SLL   = 6'b000000;
    localparam logic [5:0] FUN_SRL   = 6'b000010;
    localparam logic [5:0] FUN_SRA   = 6'b000011;
    localparam logic [5:0] FUN_SLLV  = 6'b000100;
    localparam logic [5:0] FUN_SRLV  = 6'b000110;
    localparam logic [5:0] FUN_SRAV  = 6'b000111;
    localparam logic [5:0] FUN_MFHI  = 6'b010000;
    localparam logic [5:0] FUN_MTHI  = 6'b010001;
    localparam logic [5:0] FUN_MFLO  = 6'b010010;
    localparam logic [5:0] FUN_MTLO  = 6'b010011;
    localparam logic [5:0] FUN_MULT  = 6'b011000;
    localparam logic [5:0] FUN_MULTU = 6'b011001;
    localparam logic [5:0] FUN_DIV   = 6'b011010;
    localparam logic [5:0] FUN_DIVU  = 6'b011011;
    localparam logic [5:0] FUN_ADD   = 6'b100000;
    localparam logic [5:0] FUN_ADDU  = 6'b100001;
    localparam logic [5:0] FUN_SUB   = 6'b100010;
    localparam logic [5:0] FUN_SUBU  = 6'b100011;
    localparam logic [5:0] FUN_AND   = 6'b100100;
    localparam logic [5:0] FUN_OR    = 6'b100101;
    localparam logic [5:0] FUN_XOR   = 6'b100110;
    localparam logic [5:0] FUN_NOR   = 6'b100111;
    localparam logic [5:0] FUN_SLT   = 6'b101010;
    localparam logic [5:0] FUN_SLTU  = 6'b101011;

    // COP0 rs field
    localparam logic [4:0] RS_MFC0 = 5'b00000;

    // ALU opcode encodings
    localparam logic [7:0] ALUOP_NONE  = 8'd0;
    localparam logic [7:0] ALUOP_ADD   = 8'd1;
    localparam logic [7:0] ALUOP_ADDU  = 8'd2;
    localparam logic [7:0] ALUOP_SUB   = 8'd3;
    localparam logic [7:0] ALUOP_SUBU  = 8'd4;
    localparam logic [7:0] ALUOP_AND   = 8'd5;
    localparam logic [7:0] ALUOP_OR    = 8'd6;
    localparam logic [7:0] ALUOP_XOR   = 8'd7;
    localparam logic [7:0] ALUOP_NOR   = 8'd8;
    localparam logic [7:0] ALUOP_SLT   = 8'd9;
    localparam logic [7:0] ALUOP_SLTU  = 8'd10;
    localparam logic [7:0] ALUOP_SLL   = 8'd11;
    localparam logic [7:0] ALUOP_SRL   = 8'd12;
    localparam logic [7:0] ALUOP_SRA   = 8'd13;
    localparam logic [7:0] ALUOP_SLLV  = 8'd14;
    localparam logic [7:0] ALUOP_SRLV  = 8'd15;
    localparam logic [7:0] ALUOP_SRAV  = 8'd16;
    localparam logic [7:0] ALUOP_LUI   = 8'd17;
    localparam logic [7:0] ALUOP_MFHI  = 8'd18;
    localparam logic [7:0] ALUOP_MFLO  = 8'd19;
    localparam logic [7:0] ALUOP_MTHI  = 8'd20;
    localparam logic [7:0] ALUOP_MTLO  = 8'd21;
    localparam logic [7:0] ALUOP_MULT  = 8'd22;
    localparam logic [7:0] ALUOP_MULTU = 8'd23;
    localparam logic [7:0] ALUOP_DIV   = 8'd24;
    localparam logic [7:0] ALUOP_DIVU  = 8'd25;
    localparam logic [7:0] ALUOP_MFC0  = 8'd26;

    function automatic logic [7:0] decode_aluop(input logic [31:0] instr);
        logic [7:0] op;
        op = ALUOP_NONE;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FUN_SLL:   op = ALUOP_SLL;
                    FUN_SRL:   op = ALUOP_SRL;
                    FUN_SRA:   op = ALUOP_SRA;
                    FUN_SLLV:  op = ALUOP_SLLV;
                    FUN_SRLV:  op = ALUOP_SRLV;
                    FUN_SRAV:  op = ALUOP_SRAV;
                    FUN_MFHI:  op = ALUOP_MFHI;
                    FUN_MTHI:  op = ALUOP_MTHI;
                    FUN_MFLO:  op = ALUOP_MFLO;
                    FUN_MTLO:  op = ALUOP_MTLO;
                    FUN_MULT:  op = ALUOP_MULT;
                    FUN_MULTU: op = ALUOP_MULTU;
                    FUN_DIV:   op = ALUOP_DIV;
                    FUN_DIVU:  op = ALUOP_DIVU;
                    FUN_ADD:   op = ALUOP_ADD;
                    FUN_ADDU:  op = ALUOP_ADDU;
                    FUN_SUB:   op = ALUOP_SUB;
                    FUN_SUBU:  op = ALUOP_SUBU;
                    FUN_AND:   op = ALUOP_AND;
                    FUN_OR:    op = ALUOP_OR;
                    FUN_XOR:   op = ALUOP_XOR;
                    FUN_NOR:   op = ALUOP_NOR;
                    FUN_SLT:   op = ALUOP_SLT;
                    FUN_SLTU:  op = ALUOP_SLTU;
                    default:   op = ALUOP_NONE;
                endcase
            end
            OP_ADDI:  op = ALUOP_ADD;
            OP_ADDIU: op = ALUOP_ADDU;
            OP_SLTI:  op = ALUOP_SLT;
            OP_SLTIU: op = ALUOP_SLTU;
            OP_ANDI:  op = ALUOP_AND;
            OP_ORI:   op = ALUOP_OR;
            OP_XORI:  op = ALUOP_XOR;
            OP_LUI:   op = ALUOP_LUI;
            OP_COP0:  op = (instr[25:21] == RS_MFC0) ? ALUOP_MFC0 : ALUOP_NONE;
            // Address generation for every load/store is a plain add
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: op = ALUOP_ADD;
            default:  op = ALUOP_NONE;
        endcase
        return op;
    endfunction

    // Ops that occupy HI/LO for several cycles
    function automatic logic is_md_op(input logic [7:0] op);
        return (op == ALUOP_MULT) || (op == ALUOP_MULTU) ||
               (op == ALUOP_DIV)  || (op == ALUOP_DIVU);
    endfunction

    // Any op that reads or writes HI/LO and so must wait for the MD unit
    function automatic logic is_hilo_op(input logic [7:0] op);
        return is_md_op(op) ||
               (op == ALUOP_MFHI) || (op == ALUOP_MFLO) ||
               (op == ALUOP_MTHI) || (op == ALUOP_MTLO);
    endfunction

endpackage

// File: rtl/alu_dec_md_occupancy.sv
// md_occupancy
//   HI/LO occupancy tracker. It counts the remaining multiply/divide
//   latency after an MD op enters E.
//   Ports: clk; srst (sync, active-high); start_mul/start_div (an MD op
//   loads into E this cycle); abort (an exception squashes the in-flight
//   op); cnt (remaining cycles); loaded (an MD op was loaded on the last
//   edge); busy (cnt != 0, registered); done (one-cycle pulse when the
//   countdown reaches 0).
//   Requires MUL_LAT, DIV_LAT >= 1 and 2**CNT_W > max(MUL_LAT, DIV_LAT).
import alu_dec_md_pkg::*;

module md_occupancy #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 36,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic             abort,
    output logic [CNT_W-1:0] cnt,
    output logic             loaded,
    output logic             busy,
    output logic             done
);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_reg, done_next;
    logic             busy_reg;
    logic             loaded_reg;

    // A start reloads even if the counter is non-zero. The stall logic
    // normally prevents that case, and the reload is the safe choice
    // when it does happen.
    always_comb begin
        cnt_next  = cnt_reg;
        done_next = 1'b0;
        if (start_div)
            cnt_next = CNT_W'(DIV_LAT);
        else if (start_mul)
            cnt_next = CNT_W'(MUL_LAT);
        else if (abort)
            cnt_next = '0;
        else if (cnt_reg != '0) begin
            cnt_next  = cnt_reg - 1'b1;
            done_next = (cnt_reg == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            loaded_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            done_reg   <= done_next;
            busy_reg   <= (cnt_next != '0);
            loaded_reg <= start_mul | start_div;
        end
    end

    assign cnt    = cnt_reg;
    assign done   = done_reg;
    assign busy   = busy_reg;
    assign loaded = loaded_reg;
endmodule

// File: rtl/flopenrc.sv
// flopenrc
//   Resettable, clearable, enabled register.
//   Ports: clk, srst (sync, active-high), en (load), clr (sync clear,
//   which wins over en), d/q (WIDTH bits).
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst)
            q_reg <= '0;
        else if (clr)
            q_reg <= '0;
        else if (en)
            q_reg <= d;
    end

    assign q = q_reg;
endmodule

// File: rtl/alu_dec_md.sv
// alu_dec_md
//   D->E ALU-op decoder with the E pipeline register and a HI/LO
//   multiply/divide occupancy tracker.
//   Ports: clk; rst (sync, active-low); flushE/stallE (E register
//   control); instrD (D instruction); exceptM (any set bit flushes E);
//   aluopE (registered opcode); md_busyE/md_doneE (tracker status);
//   stall_reqD (combinational HI/LO hazard request); riE (registered
//   reserved-instruction flag).
//   Build option: define ALU_DEC_RI_EN to make riE capture decode misses.
//   Without it, riE is constant 0.
import alu_dec_md_pkg::*;

module alu_dec_md #(
    parameter int ALUOP_W = 8,
    parameter int EXC_W   = 8,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 36,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flushE,
    input  logic               stallE,
    input  logic [31:0]        instrD,
    input  logic [EXC_W-1:0]   exceptM,
    output logic [ALUOP_W-1:0] aluopE,
    output logic               md_busyE,
    output logic               md_doneE,
    output logic               stall_reqD,
    output logic               riE
);
    logic             srst;
    logic [7:0]       aluop_d;
    logic             except_any;
    logic             flush_any;
    logic             load_e;
    logic             start_mul;
    logic             start_div;
    logic [CNT_W-1:0] md_cnt;
    logic             md_loaded;

    // The external reset is active-low. Internal flops use active-high srst.
    assign srst = ~rst;

    assign aluop_d    = decode_aluop(instrD);
    assign except_any = |exceptM;
    assign flush_any  = flushE | except_any;
    assign load_e     = ~flush_any & ~stallE;

    flopenrc #(.WIDTH(ALUOP_W)) u_aluop_e (
        .clk  (clk),
        .srst (srst),
        .en   (~stallE),
        .clr  (flush_any),
        .d    (ALUOP_W'(aluop_d)),
        .q    (aluopE)
    );

`ifdef ALU_DEC_RI_EN
    // Every valid table entry decodes to a non-zero opcode, so a zero
    // result is exactly a miss.
    logic ri_d;
    assign ri_d = (aluop_d == ALUOP_NONE);

    flopenrc #(.WIDTH(1)) u_ri_e (
        .clk  (clk),
        .srst (srst),
        .en   (~stallE),
        .clr  (flush_any),
        .d    (ri_d),
        .q    (riE)
    );
`else
    assign riE = 1'b0;
`endif

    // An MD op starts only when it actually enters E. A flushed or
    // stalled cycle does not start (or restart) the counter.
    assign start_mul = load_e & ((aluop_d == ALUOP_MULT) | (aluop_d == ALUOP_MULTU));
    assign start_div = load_e & ((aluop_d == ALUOP_DIV)  | (aluop_d == ALUOP_DIVU));

    md_occupancy #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_occ (
        .clk       (clk),
        .srst      (srst),
        .start_mul (start_mul),
        .start_div (start_div),
        .abort     (except_any),
        .cnt       (md_cnt),
        .loaded    (md_loaded),
        .busy      (md_busyE),
        .done      (md_doneE)
    );

    // When cnt == 1, the result is ready by the time the D op reaches E.
    // The md_loaded term covers latency-1 ops, whose counter reads 1
    // while the op still sits in E.
    assign stall_reqD = rst & is_hilo_op(aluop_d) &
                        ((md_cnt > CNT_W'(1)) | (is_md_op(8'(aluopE)) & md_loaded));
endmodule

// File: tb/tb_alu_dec_md.sv
// tb_alu_dec_md
//   Directed-vector bench for alu_dec_md using default parameters.
//   Define ALU_DEC_RI_EN for both the RTL and this bench to exercise riE.
import alu_dec_md_pkg::*;

module tb_alu_dec_md;
    localparam int ALUOP_W = 8;
    localparam int EXC_W   = 8;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 36;
    localparam int CNT_W   = 6;

    localparam logic [31:0] I_ADD  = 32'h012A4020;
    localparam logic [31:0] I_SUB  = 32'h012A4022;
    localparam logic [31:0] I_LW   = 32'h8D280004;
    localparam logic [31:0] I_SW   = 32'hAD280004;
    localparam logic [31:0] I_ORI  = 32'h35280004;
    localparam logic [31:0] I_ADDIU= 32'h25280004;
    localparam logic [31:0] I_LUI  = 32'h3C081234;
    localparam logic [31:0] I_MFC0 = 32'h40086000;
    localparam logic [31:0] I_MTC0 = 32'h40886000;
    localparam logic [31:0] I_DIV  = 32'h012A001A;
    localparam logic [31:0] I_MULT = 32'h012A0018;
    localparam logic [31:0] I_MFHI = 32'h00004010;
    localparam logic [31:0] I_MFLO = 32'h00004012;
    localparam logic [31:0] I_BADF = 32'h0000003F;
    localparam logic [31:0] I_BADO = 32'hFC000000;

    logic               clk = 1'b0;
    logic               rst;
    logic               flushE;
    logic               stallE;
    logic [31:0]        instrD;
    logic [EXC_W-1:0]   exceptM;
    logic [ALUOP_W-1:0] aluopE;
    logic               md_busyE;
    logic               md_doneE;
    logic               stall_reqD;
    logic               riE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_dec_md #(
        .ALUOP_W (ALUOP_W),
        .EXC_W   (EXC_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flushE     (flushE),
        .stallE     (stallE),
        .instrD     (instrD),
        .exceptM    (exceptM),
        .aluopE     (aluopE),
        .md_busyE   (md_busyE),
        .md_doneE   (md_doneE),
        .stall_reqD (stall_reqD),
        .riE        (riE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stall_cycles;
        int done_seen;

        rst     = 1'b0;
        flushE  = 1'b0;
        stallE  = 1'b0;
        exceptM = '0;
        instrD  = I_ADD;

        // 1. Reset
        tick();
        tick();
        check("rst_aluop", 32'(aluopE), 32'(ALUOP_NONE));
        check("rst_busy",  32'(md_busyE), 32'd0);
        check("rst_done",  32'(md_doneE), 32'd0);
        check("rst_ri",    32'(riE), 32'd0);
        check("rst_stall", 32'(stall_reqD), 32'd0);
        rst = 1'b1;
        tick();
        check("add", 32'(aluopE), 32'(ALUOP_ADD));

        // 2. Decode table and loads/stores, plus stall hold
        instrD = I_SUB;   tick(); check("sub",   32'(aluopE), 32'(ALUOP_SUB));
        instrD = I_LW;    tick(); check("lw",    32'(aluopE), 32'(ALUOP_ADD));
        instrD = I_ADDIU; tick(); check("addiu", 32'(aluopE), 32'(ALUOP_ADDU));
        instrD = I_SW;    tick(); check("sw",    32'(aluopE), 32'(ALUOP_ADD));
        instrD = I_ORI;
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", 32'(aluopE), 32'(ALUOP_ADD));
        end
        stallE = 1'b0;
        tick(); check("ori",  32'(aluopE), 32'(ALUOP_OR));
        instrD = I_LUI;  tick(); check("lui",  32'(aluopE), 32'(ALUOP_LUI));
        instrD = I_MFC0; tick(); check("mfc0", 32'(aluopE), 32'(ALUOP_MFC0));
        instrD = 32'h0;  tick(); check("nop_sll", 32'(aluopE), 32'(ALUOP_SLL));

        // 3. Divide hazard; hazard unit bubbles E while stall_reqD is high
        instrD = I_DIV;
        #1 check("div_nostall", 32'(stall_reqD), 32'd0);
        tick();
        check("div_e",    32'(aluopE), 32'(ALUOP_DIV));
        check("div_busy", 32'(md_busyE), 32'd1);
        instrD = I_MFHI;
        stall_cycles = 0;
        done_seen    = 0;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (!stall_reqD) break;
            stall_cycles++;
            flushE = 1'b1;
            tick();
            if (md_doneE) done_seen++;
        end
        check("div_stall_len", 32'(stall_cycles), 32'(DIV_LAT - 1));
        check("div_no_early_done", 32'(done_seen), 32'd0);
        flushE = 1'b0;
        tick();
        check("mfhi_e",    32'(aluopE), 32'(ALUOP_MFHI));
        check("div_done",  32'(md_doneE), 32'd1);
        check("div_idle",  32'(md_busyE), 32'd0);
        instrD = I_ADD;
        tick();
        check("div_done_1cyc", 32'(md_doneE), 32'd0);

        // 4. Exception aborts an in-flight divide
        instrD = I_DIV;
        tick();
        check("div2_busy", 32'(md_busyE), 32'd1);
        instrD = I_ADD;
        for (int i = 0; i < 3; i++) tick();
        exceptM = 8'h01;
        tick();
        check("exc_aluop", 32'(aluopE), 32'(ALUOP_NONE));
        check("exc_busy",  32'(md_busyE), 32'd0);
        check("exc_done",  32'(md_doneE), 32'd0);
        exceptM = '0;
        done_seen = 0;
        for (int i = 0; i < DIV_LAT + 4; i++) begin
            tick();
            if (md_doneE) done_seen++;
        end
        check("exc_no_done", 32'(done_seen), 32'd0);
        check("exc_after",   32'(aluopE), 32'(ALUOP_ADD));

        // 5. Flush beats start
        instrD = I_DIV;
        flushE = 1'b1;
        tick();
        check("flush_aluop", 32'(aluopE), 32'(ALUOP_NONE));
        check("flush_busy",  32'(md_busyE), 32'd0);
        flushE = 1'b0;
        instrD = I_ADD;
        tick();
        check("flush_busy2", 32'(md_busyE), 32'd0);

        // Multiply hazard: MUL_LAT=2, so one bubble
        instrD = I_MULT;
        tick();
        check("mult_e", 32'(aluopE), 32'(ALUOP_MULT));
        instrD = I_MFLO;
        #1 check("mult_stall", 32'(stall_reqD), 32'd1);
        flushE = 1'b1;
        tick();
        check("mult_stall_drop", 32'(stall_reqD), 32'd0);
        flushE = 1'b0;
        tick();
        check("mflo_e",    32'(aluopE), 32'(ALUOP_MFLO));
        check("mult_done", 32'(md_doneE), 32'd1);

        // stallE holding an MD op in E must not restart it
        instrD = I_MULT;
        tick();
        stallE = 1'b1;
        instrD = I_ADD;
        tick();
        tick();
        check("hold_mult_e",    32'(aluopE), 32'(ALUOP_MULT));
        check("hold_mult_done", 32'(md_doneE), 32'd1);
        instrD = I_MFHI;
        #1 check("hold_no_stall", 32'(stall_reqD), 32'd0);
        stallE = 1'b0;
        tick();

        // 6. Reserved-instruction flag
        instrD = I_BADO;
        tick();
        check("bad_op_aluop", 32'(aluopE), 32'(ALUOP_NONE));
`ifdef ALU_DEC_RI_EN
        check("bad_op_ri", 32'(riE), 32'd1);
`else
        check("bad_op_ri", 32'(riE), 32'd0);
`endif
        instrD = 32'h0;
        tick();
        check("nop_ri", 32'(riE), 32'd0);
        instrD = I_BADF;
        tick();
        check("bad_funct_aluop", 32'(aluopE), 32'(ALUOP_NONE));
`ifdef ALU_DEC_RI_EN
        check("bad_funct_ri", 32'(riE), 32'd1);
`else
        check("bad_funct_ri", 32'(riE), 32'd0);
`endif
        instrD = I_MTC0;
        tick();
        check("mtc0_aluop", 32'(aluopE), 32'(ALUOP_NONE));
`ifdef ALU_DEC_RI_EN
        check("mtc0_ri", 32'(riE), 32'd1);
`else
        check("mtc0_ri", 32'(riE), 32'd0);
`endif
        instrD = I_ADD;
        tick();
        check("add_ri", 32'(riE), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
